// File: rtl/dmi_jtag_dtm.sv
// dmi_jtag_dtm: JTAG debug transport module, oversampled in clk, driving a valid/ready DMI port
module dmi_jtag_dtm #(
    parameter int          ABITS  = 7,
    parameter logic [31:0] IDCODE = 32'h0000_0001,
    parameter int          IR_LEN = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    output logic             dmi_valid,
    input  logic             dmi_ready,
    output logic             dmi_write,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    input  logic [31:0]      dmi_rdata
);
    localparam int DW = ABITS + 34;
    localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(5'h01);
    localparam logic [IR_LEN-1:0] IR_DTMCS  = IR_LEN'(5'h10);
    localparam logic [IR_LEN-1:0] IR_DMI    = IR_LEN'(5'h11);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PS_DR, EX2_DR, UP_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PS_IR, EX2_IR, UP_IR
    } tap_t;
    tap_t state, nxt;
    logic [1:0] tck_s, tms_s, tdi_s;
    logic tck_q, rise, fall, tms_v, tdi_v;
    logic [IR_LEN-1:0] ir, ir_sr;
    logic [31:0] sr32, result, res_now;
    logic [DW-1:0] dmi_sr;
    logic byp, discard, done, busy, dr_lsb;
    logic [1:0] sticky, op_now;
    logic [31:0] dtmcs_cap;
    assign rise = tck_s[1] & ~tck_q;
    assign fall = ~tck_s[1] & tck_q;
    assign tms_v = tms_s[1];
    assign tdi_v = tdi_s[1];
    assign tdo_en = (state == SH_IR) || (state == SH_DR);
    assign done = dmi_valid && dmi_ready;
    assign busy = dmi_valid && !dmi_ready;
    assign res_now = (done && !dmi_write && !discard) ? dmi_rdata : result;
    assign op_now = (busy || sticky == 2'd3) ? 2'd3 : sticky;
    assign dtmcs_cap = {17'b0, 3'd1, sticky, 6'(ABITS), 4'd1};
    assign dr_lsb = (ir == IR_DMI) ? dmi_sr[0] : (ir == IR_IDCODE || ir == IR_DTMCS) ? sr32[0] : byp;
    // TAP next-state function
    always_comb begin
        nxt = state;
        case (state)
            TLR:     nxt = tms_v ? TLR    : RTI;
            RTI:     nxt = tms_v ? SEL_DR : RTI;
            SEL_DR:  nxt = tms_v ? SEL_IR : CAP_DR;
            CAP_DR:  nxt = tms_v ? EX1_DR : SH_DR;
            SH_DR:   nxt = tms_v ? EX1_DR : SH_DR;
            EX1_DR:  nxt = tms_v ? UP_DR  : PS_DR;
            PS_DR:   nxt = tms_v ? EX2_DR : PS_DR;
            EX2_DR:  nxt = tms_v ? UP_DR  : SH_DR;
            UP_DR:   nxt = tms_v ? SEL_DR : RTI;
            SEL_IR:  nxt = tms_v ? TLR    : CAP_IR;
            CAP_IR:  nxt = tms_v ? EX1_IR : SH_IR;
            SH_IR:   nxt = tms_v ? EX1_IR : SH_IR;
            EX1_IR:  nxt = tms_v ? UP_IR  : PS_IR;
            PS_IR:   nxt = tms_v ? EX2_IR : PS_IR;
            EX2_IR:  nxt = tms_v ? UP_IR  : SH_IR;
            default: nxt = tms_v ? SEL_DR : RTI;
        endcase
    end
    // Pin synchronizers and previous tck for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tck_s <= '0;
            tms_s <= '0;
            tdi_s <= '0;
            tck_q <= 1'b0;
        end else begin
            tck_s <= {tck_s[0], tck};
            tms_s <= {tms_s[0], tms};
            tdi_s <= {tdi_s[0], tdi};
            tck_q <= tck_s[1];
        end
    end
    // TAP, scan registers, status and the DMI handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= TLR;
            ir        <= IR_IDCODE;
            ir_sr     <= '0;
            sr32      <= '0;
            dmi_sr    <= '0;
            byp       <= 1'b0;
            tdo       <= 1'b0;
            sticky    <= '0;
            result    <= '0;
            discard   <= 1'b0;
            dmi_valid <= 1'b0;
            dmi_write <= 1'b0;
            dmi_addr  <= '0;
            dmi_wdata <= '0;
        end else begin
            if (done) begin
                dmi_valid <= 1'b0;
                discard   <= 1'b0;
                if (!dmi_write && !discard) result <= dmi_rdata;
            end
            if (fall && tdo_en) tdo <= (state == SH_IR) ? ir_sr[0] : dr_lsb;
            if (rise) begin
                state <= nxt;
                if (nxt == TLR) ir <= IR_IDCODE;
                case (state)
                    CAP_IR: ir_sr <= IR_LEN'(1);
                    SH_IR:  ir_sr <= {tdi_v, ir_sr[IR_LEN-1:1]};
                    UP_IR:  ir <= ir_sr;
                    CAP_DR: begin
                        byp    <= 1'b0;
                        sr32   <= (ir == IR_DTMCS) ? dtmcs_cap : IDCODE;
                        dmi_sr <= {dmi_addr, res_now, op_now};
                    end
                    SH_DR: begin
                        byp    <= tdi_v;
                        sr32   <= {tdi_v, sr32[31:1]};
                        dmi_sr <= {tdi_v, dmi_sr[DW-1:1]};
                    end
                    UP_DR: begin
                        if (ir == IR_DTMCS) begin
                            if (sr32[16] || sr32[17]) sticky <= 2'd0;
                            if (sr32[17]) begin
                                result <= '0;
                                if (busy && !dmi_write) discard <= 1'b1;
                            end
                        end else if (ir == IR_DMI) begin
                            if (dmi_valid) sticky <= 2'd3;
                            else if (sticky == 2'd0 && (dmi_sr[1:0] == 2'd1 || dmi_sr[1:0] == 2'd2)) begin
                                dmi_valid <= 1'b1;
                                dmi_write <= dmi_sr[1];
                                dmi_addr  <= dmi_sr[DW-1:34];
                                dmi_wdata <= dmi_sr[33:2];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// tb_dmi_jtag_dtm: directed JTAG scans against the DTM with a hand-driven DMI responder
module tb_dmi_jtag_dtm;
    logic clk = 1'b0, resetn = 1'b0, tck = 1'b0, tms = 1'b0, tdi = 1'b0, dmi_ready = 1'b0;
    logic [31:0] dmi_rdata = '0;
    logic tdo, tdo_en, dmi_valid, dmi_write;
    logic [6:0] dmi_addr;
    logic [31:0] dmi_wdata;
    int tests = 0, fails = 0;
    logic last_tdo, last_en, en_in, en_out;
    logic [63:0] o;
    logic [4:0] iro;

    dmi_jtag_dtm dut (
        .clk(clk), .resetn(resetn), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write), .dmi_addr(dmi_addr),
        .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one tck period, 5 clk per phase; tdo/tdo_en sampled just before the rising edge
    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        #50;
        last_tdo = tdo;
        last_en = tdo_en;
        tck = 1'b1;
        #50;
        tck = 1'b0;
    endtask

    // from Run-Test/Idle back to Run-Test/Idle
    task automatic scan_ir(input logic [4:0] v, output logic [4:0] out);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, v[i]);
            out[i] = last_tdo;
        end
        tick(1, 0); tick(0, 0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] v, output logic [63:0] out,
                           output logic ein, output logic eout);
        out = '0;
        ein = 1'b1;
        tick(1, 0); eout = last_en;
        tick(0, 0); eout |= last_en;
        tick(0, 0); eout |= last_en;
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, v[i]);
            out[i] = last_tdo;
            ein &= last_en;
        end
        tick(1, 0); eout |= last_en;
        tick(0, 0); eout |= last_en;
    endtask

    function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    task automatic pulse_ready(input logic [31:0] rd);
        dmi_rdata = rd;
        dmi_ready = 1'b1;
        #10;
        dmi_ready = 1'b0;
        dmi_rdata = '0;
    endtask

    initial begin
        #22;
        chk("reset_outputs", {dmi_valid, dmi_write, dmi_addr, dmi_wdata, tdo, tdo_en}, '0);
        resetn = 1'b1;
        #20;
        // IDCODE after Test-Logic-Reset
        repeat (5) tick(1, 0);
        tick(0, 0);
        scan_dr(32, '0, o, en_in, en_out);
        chk("idcode", o, 64'h1);
        chk("tdo_en_shift", en_in, 1'b1);
        chk("tdo_en_idle", en_out, 1'b0);
        // DTMCS capture
        scan_ir(5'h10, iro);
        chk("ir_capture", iro, 5'b00001);
        scan_dr(32, '0, o, en_in, en_out);
        chk("dtmcs", o, 64'h1071);
        // DMI write
        scan_ir(5'h11, iro);
        scan_dr(41, dmi(7'h04, 32'hDEADBEEF, 2'd2), o, en_in, en_out);
        chk("wr_req", {dmi_valid, dmi_write, dmi_addr, dmi_wdata}, {1'b1, 1'b1, 7'h04, 32'hDEADBEEF});
        #100;
        chk("wr_hold", {dmi_valid, dmi_write, dmi_addr, dmi_wdata}, {1'b1, 1'b1, 7'h04, 32'hDEADBEEF});
        pulse_ready(32'hFFFF_FFFF);
        chk("wr_drop", dmi_valid, 1'b0);
        scan_dr(41, dmi(7'h00, 32'h0, 2'd0), o, en_in, en_out);
        chk("wr_capture", o, dmi(7'h04, 32'h0, 2'd0));
        // DMI read
        scan_dr(41, dmi(7'h11, 32'h0, 2'd1), o, en_in, en_out);
        chk("rd_req", {dmi_valid, dmi_write, dmi_addr}, {1'b1, 1'b0, 7'h11});
        pulse_ready(32'h0003_0382);
        chk("rd_drop", dmi_valid, 1'b0);
        scan_dr(41, dmi(7'h00, 32'h0, 2'd0), o, en_in, en_out);
        chk("rd_capture", o, dmi(7'h11, 32'h0003_0382, 2'd0));
        // busy: second update while the responder stalls
        scan_dr(41, dmi(7'h05, 32'h0, 2'd1), o, en_in, en_out);
        scan_dr(41, dmi(7'h09, 32'h5555_AAAA, 2'd2), o, en_in, en_out);
        chk("busy_capture", o, dmi(7'h05, 32'h0003_0382, 2'd3));
        chk("busy_no_reissue", {dmi_valid, dmi_write, dmi_addr}, {1'b1, 1'b0, 7'h05});
        pulse_ready(32'h1234_5678);
        chk("busy_drop", dmi_valid, 1'b0);
        scan_dr(41, dmi(7'h00, 32'h0, 2'd0), o, en_in, en_out);
        chk("sticky_capture", o, dmi(7'h05, 32'h1234_5678, 2'd3));
        chk("sticky_no_issue", dmi_valid, 1'b0);
        scan_ir(5'h10, iro);
        scan_dr(32, '0, o, en_in, en_out);
        chk("dtmcs_sticky", o, 64'h1C71);
        scan_dr(32, 64'h1_0000, o, en_in, en_out);
        chk("dtmcs_sticky2", o, 64'h1C71);
        scan_dr(32, '0, o, en_in, en_out);
        chk("dtmcs_cleared", o, 64'h1071);
        scan_ir(5'h11, iro);
        scan_dr(41, dmi(7'h00, 32'h0, 2'd0), o, en_in, en_out);
        chk("dmi_cleared", o, dmi(7'h05, 32'h1234_5678, 2'd0));
        // asynchronous reset mid-transaction
        scan_dr(41, dmi(7'h22, 32'h0, 2'd1), o, en_in, en_out);
        chk("rst_pre_valid", dmi_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_valid", dmi_valid, 1'b0);
        chk("rst_tdo", {tdo, tdo_en, dmi_addr}, '0);
        #9;
        resetn = 1'b1;
        #10;
        tick(0, 0);
        scan_dr(32, '0, o, en_in, en_out);
        chk("rst_ir_idcode", o, 64'h1);
        // bypass
        scan_ir(5'h1F, iro);
        scan_dr(8, 64'hB6, o, en_in, en_out);
        chk("bypass", o, 64'h6C);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
